// File: rtl/axi_lite_reg_master.sv
// axi_lite_reg_master: single-outstanding AXI4-Lite initiator behind a command/response port,
// with a sticky per-transaction timeout flag for slaves that never answer.
module axi_lite_reg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 12,
  parameter int C_TIMEOUT = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WR_B = 3'd2;
  localparam logic [2:0] S_RD_A = 3'd3;
  localparam logic [2:0] S_RD_D = 3'd4;
  localparam logic [2:0] S_RSP  = 3'd5;
  localparam int CW = $clog2(C_TIMEOUT + 1);

  logic [2:0]                        r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_bready;
  logic                              r_arvalid;
  logic                              r_rready;
  logic                              r_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;
  logic [CW-1:0]                     r_cnt;
  logic                              r_terr;
  logic                              w_accept;
  logic                              w_busy;
  logic                              w_aw_done;
  logic                              w_w_done;

  assign cmd_ready     = r_state == S_IDLE;
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_busy        = (r_state == S_WR) || (r_state == S_WR_B) || (r_state == S_RD_A) || (r_state == S_RD_D);
  // a channel counts as done if it already handshook or handshakes at this edge
  assign w_aw_done     = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done      = !r_wvalid || M_AXI_WREADY;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign timeout_err   = r_terr;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state     <= S_IDLE;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (cmd_wr) begin
            r_awaddr  <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR;
          end else begin
            r_araddr  <= cmd_addr;
            r_arvalid <= 1'b1;
            r_state   <= S_RD_A;
          end
        end
        S_WR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY) r_wvalid <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: if (M_AXI_BVALID) begin
          r_bready    <= 1'b0;
          r_rsp_resp  <= M_AXI_BRESP;
          r_rsp_rdata <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RD_A: if (M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_D;
        end
        S_RD_D: if (M_AXI_RVALID) begin
          r_rready    <= 1'b0;
          r_rsp_resp  <= M_AXI_RRESP;
          r_rsp_rdata <= M_AXI_RDATA;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // flag only reports; the FSM keeps waiting on the slave
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else if (w_busy && r_cnt != CW'(C_TIMEOUT)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(C_TIMEOUT - 1)) r_terr <= 1'b1;
    end
  end
endmodule
